// File: rtl/seg7_scan_mux_if.sv
// Control and display signals between a scan-driver user and seg7_scan_mux.
// The master supplies the value/strobe side; the slave drives the digit outputs.
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   val;
    logic [DIGITS-1:0]     dp_in;
    logic                  lzb;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     an;
    logic                  dp;
    logic                  pend;
    logic                  frame_tick;

    modport master (
        output en, load, val, dp_in, lzb,
        input  nib, an, dp, pend, frame_tick
    );

    modport slave (
        input  en, load, val, dp_in, lzb,
        output nib, an, dp, pend, frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment scan driver with frame-aligned
// value update, per-slot dead time and optional leading-zero blanking.
module seg7_scan_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_mux_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        PH_GAP,
        PH_DRIVE
    } phase_e;

    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   shown_nib;
    logic [DIGITS-1:0][3:0]   pend_nib;
    logic [DIGITS-1:0]        shown_dp;
    logic [DIGITS-1:0]        pend_dp;
    logic                     pend_q;

    logic                     slot_end;
    logic                     last_slot;
    logic                     frame_end;
    logic                     active;
    phase_e                   phase;
    logic [DIGITS-1:0]        blank;
    logic                     zero_above;

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign last_slot = (idx == IW'(DIGITS - 1));
    assign frame_end = bus.en && slot_end && last_slot;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (bus.en) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= last_slot ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // NOTE: the value registers are reset (not left free) because a reset
    // must discard any pending value and bring the display back to zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_nib <= '0;
            shown_dp  <= '0;
            pend_nib  <= '0;
            pend_dp   <= '0;
            pend_q    <= 1'b0;
        end else begin
            if (frame_end && pend_q) begin
                shown_nib <= pend_nib;
                shown_dp  <= pend_dp;
            end
            if (bus.load) begin
                pend_nib <= bus.val;
                pend_dp  <= bus.dp_in;
            end
            // A load on the boundary edge re-arms pend after the old value moves.
            pend_q <= bus.load | (pend_q & ~frame_end);
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (shown_nib[k] == 4'h0);
            blank[k]   = bus.lzb && zero_above;
        end
    end

    // Reset gates the outputs directly so anodes stay dark while rst_n is low.
    assign active = rst_n && bus.en;
    assign phase  = (int'(cnt) < DEAD) ? PH_GAP : PH_DRIVE;

    always_comb begin
        bus.nib        = shown_nib[idx];
        bus.an         = '1;
        bus.dp         = 1'b1;
        bus.pend       = pend_q;
        bus.frame_tick = active && (cnt == '0) && (idx == '0);
        if (active && (phase == PH_DRIVE) && !blank[idx]) begin
            bus.an[idx] = 1'b0;
            bus.dp      = ~shown_dp[idx];
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux (DIGITS=4, DIV=4, DEAD=1) with an
// enabled-cycle-count reference model compared on every falling edge.
module tb_seg7_scan_mux;
    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int DEAD   = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg7_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_mux #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the scan is just the number of enabled edges since reset.
    int          t = 0;
    logic [15:0] m_shown = '0, m_pval = '0;
    logic [3:0]  m_sdp = '0, m_pdp = '0;
    logic        m_pend = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; m_shown = '0; m_pval = '0; m_sdp = '0; m_pdp = '0; m_pend = 1'b0;
        end else begin
            logic boundary;
            boundary = bus.en && (t % FRAME == FRAME - 1);
            if (boundary && m_pend) begin
                m_shown = m_pval;
                m_sdp   = m_pdp;
            end
            if (bus.load) begin
                m_pval = bus.val; m_pdp = bus.dp_in; m_pend = 1'b1;
            end else if (boundary) begin
                m_pend = 1'b0;
            end
            if (bus.en) t = t + 1;
        end
    end

    always @(negedge clk) begin
        int slot, pos;
        logic blank, lit, e_dp, e_ft;
        logic [3:0] e_nib, e_an;
        slot  = (t / DIV) % DIGITS;
        pos   = t % DIV;
        e_nib = 4'(m_shown >> (4 * slot));
        blank = bus.lzb && (slot > 0) && ((m_shown >> (4 * slot)) == 16'h0);
        lit   = rst_n && bus.en && (pos >= DEAD) && !blank;
        e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
        e_dp  = lit ? ~m_sdp[slot] : 1'b1;
        e_ft  = rst_n && bus.en && (t % FRAME == 0);
        check("model.nib",  {28'b0, bus.nib},        {28'b0, e_nib});
        check("model.an",   {28'b0, bus.an},         {28'b0, e_an});
        check("model.dp",   {31'b0, bus.dp},         {31'b0, e_dp});
        check("model.pend", {31'b0, bus.pend},       {31'b0, m_pend});
        check("model.tick", {31'b0, bus.frame_tick}, {31'b0, e_ft});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] n, input logic [3:0] a,
                              input logic d, input logic p, input logic f);
        check({tag, ".nib"},  {28'b0, bus.nib},        {28'b0, n});
        check({tag, ".an"},   {28'b0, bus.an},         {28'b0, a});
        check({tag, ".dp"},   {31'b0, bus.dp},         {31'b0, d});
        check({tag, ".pend"}, {31'b0, bus.pend},       {31'b0, p});
        check({tag, ".tick"}, {31'b0, bus.frame_tick}, {31'b0, f});
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load = 1'b1; bus.val = v; bus.dp_in = d;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 1'b1; bus.load = 1'b0; bus.val = '0; bus.dp_in = '0; bus.lzb = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        expect_out("reset", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 expect_out("release", 4'h0, 4'hF, 1'b1, 1'b0, 1'b1);
        cyc(1);  expect_out("first_drive", 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);          // t=1
        cyc(4);  do_load(16'h1234, 4'b0100);                                        // t=5
        cyc(1);  bus.load = 1'b0;                                                   // t=6
        expect_out("pend_set", 4'h0, 4'hD, 1'b1, 1'b1, 1'b0);
        cyc(9);  expect_out("pre_boundary", 4'h0, 4'h7, 1'b1, 1'b1, 1'b0);         // t=15
        cyc(1);  expect_out("boundary", 4'h4, 4'hF, 1'b1, 1'b0, 1'b1);             // t=16
        cyc(1);  expect_out("v1234_s0", 4'h4, 4'hE, 1'b1, 1'b0, 1'b0);             // t=17
        cyc(4);  expect_out("v1234_s1", 4'h3, 4'hD, 1'b1, 1'b0, 1'b0);             // t=21
        cyc(4);  expect_out("v1234_s2_dp", 4'h2, 4'hB, 1'b0, 1'b0, 1'b0);          // t=25
        cyc(4);  expect_out("v1234_s3", 4'h1, 4'h7, 1'b1, 1'b0, 1'b0);             // t=29
        do_load(16'h0030, 4'b1111); bus.lzb = 1'b1;
        cyc(1);  bus.load = 1'b0; bus.dp_in = '0;                                   // t=30
        cyc(3);  expect_out("lzb_s0", 4'h0, 4'hE, 1'b0, 1'b0, 1'b0);               // t=33
        cyc(4);  expect_out("lzb_s1", 4'h3, 4'hD, 1'b0, 1'b0, 1'b0);               // t=37
        cyc(4);  expect_out("lzb_s2", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);               // t=41
        cyc(4);  expect_out("lzb_s3", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);               // t=45
        do_load(16'h0000, 4'b0000);
        cyc(1);  bus.load = 1'b0;                                                   // t=46
        cyc(3);  expect_out("zero_s0", 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);              // t=49
        cyc(4);  expect_out("zero_s1", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);              // t=53
        bus.lzb = 1'b0;
        cyc(2);  do_load(16'hAAAA, 4'b0000);                                        // t=55
        cyc(1);  bus.load = 1'b0;                                                   // t=56
        cyc(7);  do_load(16'hBEEF, 4'b0000);                                        // t=63
        cyc(1);  bus.load = 1'b0;                                                   // t=64
        expect_out("coincident", 4'hA, 4'hF, 1'b1, 1'b1, 1'b1);
        cyc(1);  expect_out("aaaa_s0", 4'hA, 4'hE, 1'b1, 1'b1, 1'b0);              // t=65
        cyc(15); expect_out("beef_boundary", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);        // t=80
        cyc(5);  expect_out("beef_s1", 4'hE, 4'hD, 1'b1, 1'b0, 1'b0);              // t=85
        cyc(8);  expect_out("beef_s3", 4'hB, 4'h7, 1'b1, 1'b0, 1'b0);              // t=93
        cyc(12); bus.en = 1'b0;                                                     // t=105
        #1 expect_out("hold", 4'hE, 4'hF, 1'b1, 1'b0, 1'b0);
        cyc(10); expect_out("held", 4'hE, 4'hF, 1'b1, 1'b0, 1'b0);                 // t=105
        bus.en = 1'b1;
        #1 expect_out("resume", 4'hE, 4'hB, 1'b1, 1'b0, 1'b0);
        cyc(2);  expect_out("s2_last", 4'hE, 4'hB, 1'b1, 1'b0, 1'b0);              // t=107
        cyc(1);  expect_out("s3_gap", 4'hB, 4'hF, 1'b1, 1'b0, 1'b0);               // t=108
        cyc(4);  expect_out("frame_end", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);            // t=112
        cyc(2);  do_load(16'h1234, 4'b1111);                                        // t=114
        cyc(1);  bus.load = 1'b0;                                                   // t=115
        expect_out("pend_mid", 4'hF, 4'hE, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 expect_out("mid_reset", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        cyc(2);  rst_n = 1'b1;
        #1 expect_out("rerelease", 4'h0, 4'hF, 1'b1, 1'b0, 1'b1);
        cyc(1);  expect_out("post_reset_s0", 4'h0, 4'hE, 1'b1, 1'b0, 1'b0);        // t=1
        cyc(4);  expect_out("post_reset_s1", 4'h0, 4'hD, 1'b1, 1'b0, 1'b0);        // t=5
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
